// File: rtl/seg_scan_ctrl_if.sv
// Bundle between application logic and the 7-segment scan controller:
// display inputs (value, enables, dp, blink, lz, brightness) and pin-level outputs.
interface seg_scan_ctrl_if #(
    parameter int DIGITS   = 6,
    parameter int BRIGHT_W = 3
);
    logic [4*DIGITS-1:0] din;
    logic [DIGITS-1:0]   din_mask;
    logic [DIGITS-1:0]   point;
    logic [DIGITS-1:0]   blink_mask;
    logic                lz_blank;
    logic [BRIGHT_W-1:0] bright;
    logic [7:0]          seg_data;
    logic [DIGITS-1:0]   seg_sel;
    logic                frame_done;

    // No handshake: inputs are sampled once per frame, outputs are free-running pin levels.
    modport master (
        output din, din_mask, point, blink_mask, lz_blank, bright,
        input  seg_data, seg_sel, frame_done
    );

    modport slave (
        input  din, din_mask, point, blink_mask, lz_blank, bright,
        output seg_data, seg_sel, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: frame-latched hex display with blink,
// leading-zero suppression, PWM brightness and a dark guard interval per slot.
module seg_scan_ctrl #(
    parameter int DIGITS         = 6,
    parameter int SCAN_CYCLES    = 50000,
    parameter int GUARD_CYCLES   = 500,
    parameter int BRIGHT_W       = 3,
    parameter int BLINK_CYCLES   = 25000000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    seg_scan_ctrl_if.slave bus
);

    localparam int CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int STEP  = (SCAN_CYCLES - GUARD_CYCLES) >> BRIGHT_W;

    localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                blink_ph_q, blink_ph_d;

    logic [4*DIGITS-1:0] din_s_q, din_s_d;
    logic [DIGITS-1:0]   mask_s_q, mask_s_d;
    logic [DIGITS-1:0]   point_s_q, point_s_d;
    logic [DIGITS-1:0]   blink_s_q, blink_s_d;
    logic                lz_s_q, lz_s_d;
    logic [BRIGHT_W-1:0] bright_s_q, bright_s_d;

    logic [7:0]          seg_data_q, seg_data_d;
    logic [DIGITS-1:0]   seg_sel_q, seg_sel_d;
    logic                frame_done_q, frame_done_d;

    logic                slot_end, frame_end, blink_end;
    logic [DIGITS-1:0]   lz_supp;
    logic                lz_seen;
    logic [3:0]          nibble;
    logic                visible, in_win;
    logic [31:0]         cnt_ext, win_hi;
    logic [7:0]          seg_on;
    logic [DIGITS-1:0]   sel_on;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Slot / digit / blink timing and the frame-boundary shadow capture.
    always_comb begin
        slot_end  = (cnt_q == CNT_W'(SCAN_CYCLES - 1));
        frame_end = slot_end && (idx_q == IDX_W'(DIGITS - 1));
        blink_end = (blink_cnt_q == BLK_W'(BLINK_CYCLES - 1));

        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = frame_end ? '0 : idx_q + 1'b1;
        end

        blink_cnt_d = blink_end ? '0 : blink_cnt_q + 1'b1;
        blink_ph_d  = blink_ph_q ^ blink_end;

        din_s_d    = din_s_q;
        mask_s_d   = mask_s_q;
        point_s_d  = point_s_q;
        blink_s_d  = blink_s_q;
        lz_s_d     = lz_s_q;
        bright_s_d = bright_s_q;
        if (frame_end) begin
            din_s_d    = bus.din;
            mask_s_d   = bus.din_mask;
            point_s_d  = bus.point;
            blink_s_d  = bus.blink_mask;
            lz_s_d     = bus.lz_blank;
            bright_s_d = bus.bright;
        end

        frame_done_d = frame_end;
    end

    // Walk from the most significant digit down; everything above the first
    // enabled nonzero digit is dark, digit 0 always survives.
    always_comb begin
        lz_seen = 1'b0;
        lz_supp = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (mask_s_q[i] && (din_s_q[4*i +: 4] != 4'h0)) begin
                lz_seen = 1'b1;
            end
            lz_supp[i] = lz_s_q && !lz_seen && (i != 0);
        end
    end

    always_comb begin
        nibble  = din_s_q[4*int'(idx_q) +: 4];
        visible = mask_s_q[idx_q] && !lz_supp[idx_q] && !(blink_ph_q && blink_s_q[idx_q]);

        // 32-bit arithmetic so the window end cannot wrap at full brightness.
        cnt_ext = 32'(cnt_q);
        win_hi  = 32'(GUARD_CYCLES) + 32'(STEP) * (32'(bright_s_q) + 32'd1);
        in_win  = (cnt_ext >= 32'(GUARD_CYCLES)) && (cnt_ext < win_hi);

        seg_on = {point_s_q[idx_q], hex7(nibble)};
        sel_on = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;

        seg_data_d = SEG_OFF;
        seg_sel_d  = SEL_OFF;
        if (in_win && visible) begin
            seg_data_d = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
            seg_sel_d  = (SEL_ACTIVE_LOW != 0) ? ~sel_on : sel_on;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            blink_cnt_q  <= '0;
            blink_ph_q   <= 1'b0;
            din_s_q      <= '0;
            mask_s_q     <= '0;
            point_s_q    <= '0;
            blink_s_q    <= '0;
            lz_s_q       <= 1'b0;
            bright_s_q   <= '0;
            seg_data_q   <= SEG_OFF;
            seg_sel_q    <= SEL_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_ph_q   <= blink_ph_d;
            din_s_q      <= din_s_d;
            mask_s_q     <= mask_s_d;
            point_s_q    <= point_s_d;
            blink_s_q    <= blink_s_d;
            lz_s_q       <= lz_s_d;
            bright_s_q   <= bright_s_d;
            seg_data_q   <= seg_data_d;
            seg_sel_q    <= seg_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg_data   = seg_data_q;
    assign bus.seg_sel    = seg_sel_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle-level reference model plus directed literal
// checks of scan timing, decode, suppression, tearing, blink and reset.
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int SCAN   = 16;
    localparam int GUARD  = 2;
    localparam int BW     = 2;
    localparam int BLINK  = 256;
    localparam int STEP   = (SCAN - GUARD) >> BW;
    localparam int FRAME  = SCAN * DIGITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.DIGITS(DIGITS), .BRIGHT_W(BW)) bus ();

    seg_scan_ctrl #(
        .DIGITS(DIGITS), .SCAN_CYCLES(SCAN), .GUARD_CYCLES(GUARD), .BRIGHT_W(BW),
        .BLINK_CYCLES(BLINK), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    // Reference model: outputs after edge n reflect scan position n-1 since reset.
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int         m_n       = 0;
    logic [15:0] sh_din   = '0;
    logic [3:0]  sh_mask  = '0;
    logic [3:0]  sh_point = '0;
    logic [3:0]  sh_blink = '0;
    logic        sh_lz    = 1'b0;
    logic [1:0]  sh_bright = '0;
    logic [3:0]  exp_sel  = 4'hF;
    logic [7:0]  exp_data = 8'hFF;
    logic        exp_fd   = 1'b0;

    function automatic logic [12:0] model_out(int m);
        int cnt, idx, top;
        logic phase, vis, inwin;
        logic [3:0] sel;
        logic [7:0] data;
        cnt   = m % SCAN;
        idx   = (m / SCAN) % DIGITS;
        phase = ((m / BLINK) % 2) == 1;
        top   = -1;
        for (int i = 0; i < DIGITS; i++)
            if (sh_mask[i] && sh_din[4*i +: 4] != 4'h0) top = i;
        vis   = sh_mask[idx] && !(sh_lz && idx > top && idx != 0) && !(phase && sh_blink[idx]);
        inwin = cnt >= GUARD && cnt < GUARD + STEP * (int'(sh_bright) + 1);
        sel   = 4'hF;
        data  = 8'hFF;
        if (vis && inwin) begin
            sel  = ~(4'b0001 << idx);
            data = ~{sh_point[idx], seg_tab[sh_din[4*idx +: 4]]};
        end
        return {sel, data, (m % FRAME) == FRAME - 1};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n <= 0;
            sh_din <= '0; sh_mask <= '0; sh_point <= '0; sh_blink <= '0;
            sh_lz <= 1'b0; sh_bright <= '0;
            exp_sel <= 4'hF; exp_data <= 8'hFF; exp_fd <= 1'b0;
        end else begin
            {exp_sel, exp_data, exp_fd} <= model_out(m_n);
            m_n <= m_n + 1;
            if (m_n % FRAME == FRAME - 1) begin
                sh_din <= bus.din; sh_mask <= bus.din_mask; sh_point <= bus.point;
                sh_blink <= bus.blink_mask; sh_lz <= bus.lz_blank; sh_bright <= bus.bright;
            end
        end
    end

    int n_vec  = 0;
    int n_fail = 0;
    logic [3:0] g_sel  [FRAME];
    logic [7:0] g_data [FRAME];
    logic       g_fd   [FRAME];
    logic [3:0] sel_lit [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        n_vec++;
        if (bus.seg_sel !== exp_sel || bus.seg_data !== exp_data || bus.frame_done !== exp_fd) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t sel=%h exp %h data=%h exp %h fd=%b exp %b",
                     $time, bus.seg_sel, exp_sel, bus.seg_data, exp_data, bus.frame_done, exp_fd);
        end
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) return;
        end
        check("frame_done_timeout", 32'd0, 32'd1);
    endtask

    // g[j] holds the outputs reflecting scan position j of the current frame.
    task automatic grab_frame();
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clk);
            g_sel[j] = bus.seg_sel; g_data[j] = bus.seg_data; g_fd[j] = bus.frame_done;
        end
    endtask

    function automatic int on_count(int d, int c0, int c1);
        int n = 0;
        for (int c = c0; c <= c1; c++) if (g_sel[SCAN*d + c] != 4'hF) n++;
        return n;
    endfunction

    function automatic int fd_count();
        int n = 0;
        for (int j = 0; j < FRAME; j++) if (g_fd[j]) n++;
        return n;
    endfunction

    task automatic set_inputs(logic [15:0] d, logic [3:0] mk, logic [3:0] pt,
                              logic [3:0] bl, logic lz, logic [1:0] br);
        bus.din = d; bus.din_mask = mk; bus.point = pt;
        bus.blink_mask = bl; bus.lz_blank = lz; bus.bright = br;
    endtask

    initial begin
        int on0, on1, dp_bad, hold;
        logic [15:0] rd;
        set_inputs(16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        fork
            forever begin
                @(negedge clk);
                cmp_cycle();
            end
        join_none

        @(negedge clk);
        #1;
        check("reset_sel", 32'(bus.seg_sel), 32'hF);
        check("reset_data", 32'(bus.seg_data), 32'hFF);
        check("reset_fd", 32'(bus.frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: full brightness scan
        set_inputs(16'h12AF, 4'hF, 4'h0, 4'h0, 1'b0, 2'd3);
        wait_frame(); wait_frame(); grab_frame();
        for (int d = 0; d < DIGITS; d++) begin
            check($sformatf("s1_on_cnt_d%0d", d), 32'(on_count(d, 0, SCAN - 1)), 32'd12);
            check($sformatf("s1_guard_d%0d", d), 32'(g_sel[SCAN*d + 1]), 32'hF);
            check($sformatf("s1_first_on_d%0d", d), 32'(g_sel[SCAN*d + 2]), 32'(sel_lit[d]));
            check($sformatf("s1_tail_off_d%0d", d), 32'(g_sel[SCAN*d + 14]), 32'hF);
        end
        check("s1_data_d0", 32'(g_data[5]), 32'h8E);
        check("s1_data_d1", 32'(g_data[SCAN + 5]), 32'h88);
        check("s1_data_d2", 32'(g_data[2*SCAN + 5]), 32'hA4);
        check("s1_data_d3", 32'(g_data[3*SCAN + 5]), 32'hF9);
        check("s1_fd_count", 32'(fd_count()), 32'd1);
        check("s1_fd_pos", 32'(g_fd[FRAME - 1]), 32'd1);

        // 2: minimum brightness
        bus.bright = 2'd0;
        wait_frame(); wait_frame(); grab_frame();
        for (int d = 0; d < DIGITS; d++) begin
            check($sformatf("s2_on_cnt_d%0d", d), 32'(on_count(d, 0, SCAN - 1)), 32'd3);
            check($sformatf("s2_guard_d%0d", d), 32'(on_count(d, 0, 1)), 32'd0);
            check($sformatf("s2_last_on_d%0d", d), 32'(g_sel[SCAN*d + 4]), 32'(sel_lit[d]));
        end

        // 3: leading-zero suppression
        set_inputs(16'h0005, 4'hF, 4'h0, 4'h0, 1'b1, 2'd3);
        wait_frame(); wait_frame(); grab_frame();
        check("s3_upper_dark", 32'(on_count(1, 0, 3*SCAN - 1)), 32'd0);
        check("s3_d0_data", 32'(g_data[5]), 32'h92);
        bus.din = 16'h0000;
        wait_frame(); wait_frame(); grab_frame();
        check("s3z_upper_dark", 32'(on_count(1, 0, 3*SCAN - 1)), 32'd0);
        check("s3z_d0_data", 32'(g_data[5]), 32'hC0);

        // 4: change input mid-frame, must not tear
        set_inputs(16'h1111, 4'hF, 4'h0, 4'h0, 1'b0, 2'd3);
        wait_frame(); wait_frame();
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clk);
            g_sel[j] = bus.seg_sel; g_data[j] = bus.seg_data; g_fd[j] = bus.frame_done;
            if (j == SCAN + 4) bus.din = 16'h2222;
        end
        check("s4_old_d2", 32'(g_data[2*SCAN + 5]), 32'hF9);
        check("s4_old_d3", 32'(g_data[3*SCAN + 5]), 32'hF9);
        check("s4_fd_end", 32'(g_fd[FRAME - 1]), 32'd1);
        grab_frame();
        check("s4_new_d0_first", 32'(g_data[2]), 32'hA4);
        check("s4_new_d0", 32'(g_data[5]), 32'hA4);

        // 5: blink on digit 1, dp on digit 0
        set_inputs(16'h1111, 4'hF, 4'b0001, 4'b0010, 1'b0, 2'd3);
        wait_frame(); wait_frame();
        on0 = 0; on1 = 0; dp_bad = 0;
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            if (bus.seg_sel == 4'hD) begin
                if (((m_n - 1) / BLINK) % 2 == 1) on1++; else on0++;
            end
            if (bus.seg_sel == 4'hE && bus.seg_data != 8'h79) dp_bad++;
        end
        check("s5_blink_dark", 32'(on1), 32'd0);
        check("s5_blink_lit", 32'(on0 > 0), 32'd1);
        check("s5_dp_bad", 32'(dp_bad), 32'd0);

        // 6: reset mid-frame
        bus.blink_mask = 4'h0;
        wait_frame();
        repeat (2*SCAN + 5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s6_rst_sel", 32'(bus.seg_sel), 32'hF);
        check("s6_rst_data", 32'(bus.seg_data), 32'hFF);
        check("s6_rst_fd", 32'(bus.frame_done), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        grab_frame();
        check("s6_blank_frame", 32'(on_count(0, 0, FRAME - 1)), 32'd0);
        check("s6_fd_count", 32'(fd_count()), 32'd1);
        check("s6_fd_pos", 32'(g_fd[FRAME - 1]), 32'd1);

        // random stimulus, checked by the model every cycle
        for (int it = 0; it < 50; it++) begin
            @(negedge clk);
            rd = 16'($urandom);
            for (int i = 0; i < DIGITS; i++)
                if ($urandom_range(0, 2) == 0) rd[4*i +: 4] = 4'h0;
            set_inputs(rd, 4'($urandom), 4'($urandom), 4'($urandom),
                       1'($urandom), 2'($urandom));
            hold = $urandom_range(10, 150);
            if (it == 25) begin
                #2 rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
            repeat (hold) @(negedge clk);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
